pwm_generator: RTL and testbench
================================

Name: pwm_generator

Overview:
- Downstream stage of the 6-bit rate limiter. Consumes the limited 6-bit level (0..63) and converts it into a fixed-period, glitch-free PWM waveform.
- Duty is double-buffered: a new level takes effect only at a period boundary, so rate-limited steps never produce runt pulses.
- Supports a clock prescaler and a clean enable/drain sequence, so the output stops only at a period end.

Parameters:
- PRESCALE, 1, clocks per PWM tick. Legal range 1..256. Period = 64*PRESCALE clocks.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active low (0 = reset).
- en  input  1  run request, level-sensitive.
- duty  input  6  requested duty level 0..63, driven by the rate limiter output.
- pwm_out  output  1  PWM waveform, registered.
- period_start  output  1  one-clock pulse, registered, marks the first tick of each period.
- busy  output  1  high while not IDLE.
- duty_active  output  6  shadow duty currently in use.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; pre=0; cnt=0; duty_active=0.
  - pwm_out=0; period_start=0; busy=0.
  - Release is synchronous to the next clk edge. Reset mid-period aborts immediately, with no drain.
- Internal counters:
  - pre is an 8-bit prescale counter, 0..PRESCALE-1.
  - cnt is a 6-bit tick counter, 0..63, wrapping 63->0 modulo 64. No saturation.
  - tick = (pre==PRESCALE-1). When PRESCALE=1, tick=1 every clock.
- State machine (IDLE, RUN, DRAIN):
  - IDLE: pre, cnt held at 0. If en=1: duty_active<=duty, go to RUN. Otherwise stay.
  - RUN:
    - Each clk: pre<=tick?0:pre+1.
    - On tick: cnt<=cnt+1.
    - On tick with cnt==63: cnt<=0 and duty_active<=duty (the only reload point in RUN).
    - If en=0 (sampled every clk): go to DRAIN. Counters continue.
  - DRAIN:
    - Counters advance as in RUN.
    - If en=1: return to RUN, with no period restart.
    - On tick with cnt==63: go to IDLE, with cnt<=0, pre<=0 and no duty reload.
    - If en=1 on that same wrap cycle, RUN wins: reload and continue.
- Outputs, all registered from current-cycle state, so they lag the counters by one clock:
  - pwm_out <= (state!=IDLE) && (cnt < duty_active).
  - period_start <= (state!=IDLE) && cnt==0 && pre==0.
  - busy <= (state!=IDLE) after the state update, i.e. busy goes high the edge after en is seen and low the edge IDLE is entered.
- Duty rules:
  - duty=0 -> pwm_out never high.
  - duty=63 -> high 63 of 64 ticks.
  - High time = duty_active*PRESCALE clocks per period.
  - Changes on duty mid-period are ignored until the next wrap.
- First period: en rises at edge E0 (IDLE->RUN, duty loaded). At E1, period_start=1 and pwm_out=(duty!=0).
- Final period: the last high pulse is completed. pwm_out=0 from the edge after the DRAIN->IDLE transition.

Test Plan:
- Reset hold, then PRESCALE=1, duty=16, en=1 -> period_start every 64 clocks; pwm_out high exactly 16 clocks per period, starting the cycle after en is sampled.
- PRESCALE=4, duty=10 -> period 256 clocks; pwm_out high 40 consecutive clocks from period_start.
- duty changes 16->40 at cnt=20 -> current period stays 16 high; next period, with duty_active=40 from the wrap, is 40 high. Verify no pulse shorter than 16 appears.
- duty=0 then duty=63, with PRESCALE=1 -> zero high clocks, then 63 high/1 low per 64-clock period.
- en dropped at cnt=30, duty=50 -> busy stays 1; pwm_out finishes the 50-clock high pulse and the period ends at cnt=63; then IDLE with pwm_out=0, busy=0, no further period_start. Repeat with en re-raised at cnt=40 -> continuous operation, no period restart.
- rst asserted asynchronously mid-high-pulse (between clk edges) -> pwm_out, busy, period_start and duty_active go to 0 immediately. After release with en=1 -> a fresh period starts with period_start.

Source files
------------

// File: rtl/pwm_generator.sv
// ----------------------------------------------------------------------------
// pwm_generator
//
// Converts the 6-bit level from the upstream rate limiter into a fixed-period
// PWM waveform. The period is 64 ticks, and one tick lasts PRESCALE clocks.
// The requested level is copied into a shadow register (duty_active) only at
// a period boundary. A level change in the middle of a period therefore
// cannot shorten or lengthen the pulse that is already running.
//
// When en drops, the block finishes the current period (DRAIN) and then
// stops. Raising en again during DRAIN resumes operation without restarting
// the period. Reset aborts at once and does not drain.
//
// Parameters
//   PRESCALE      clocks per PWM tick, 1..256
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   en            run request, level-sensitive
//   duty          requested level 0..63
//   pwm_out       registered PWM waveform; high duty_active*PRESCALE clocks
//   period_start  registered one-clock pulse on the first tick of a period
//   busy          registered, high whenever the FSM is not IDLE
//   duty_active   shadow duty currently in use
//   dbg_state     FSM state for checkers: 0 = IDLE, 1 = RUN, 2 = DRAIN
//
// The registered outputs are computed from the counters of the current cycle,
// so they lag the counters by one clock.
// ----------------------------------------------------------------------------
module pwm_generator #(
   parameter int PRESCALE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [5:0] duty,
   output logic       pwm_out,
   output logic       period_start,
   output logic       busy,
   output logic [5:0] duty_active,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

   state_t     state;
   logic [7:0] pre;
   logic [5:0] cnt;
   logic       tick;
   logic       wrap;

   assign tick      = (pre == PRE_LAST);
   // Last tick of the period; this is the only point where duty reloads
   // or where DRAIN may stop.
   assign wrap      = tick && (cnt == 6'd63);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         pre          <= 8'd0;
         cnt          <= 6'd0;
         duty_active  <= 6'd0;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
         busy         <= 1'b0;
      end else begin
         // The waveform outputs use the pre-update counters and state.
         pwm_out      <= (state != IDLE) && (cnt < duty_active);
         period_start <= (state != IDLE) && (cnt == 6'd0) && (pre == 8'd0);

         case (state)
            IDLE: begin
               pre <= 8'd0;
               cnt <= 6'd0;
               if (en) begin
                  duty_active <= duty;
                  state       <= RUN;
                  busy        <= 1'b1;
               end else begin
                  busy <= 1'b0;
               end
            end

            RUN: begin
               pre <= tick ? 8'd0 : pre + 8'd1;
               if (tick) cnt <= cnt + 6'd1;   // 63 wraps to 0
               if (wrap) duty_active <= duty;
               state <= en ? RUN : DRAIN;
               busy  <= 1'b1;
            end

            DRAIN: begin
               pre <= tick ? 8'd0 : pre + 8'd1;
               if (tick) cnt <= cnt + 6'd1;
               if (en) begin
                  // Resuming wins over stopping, even on the wrap cycle.
                  if (wrap) duty_active <= duty;
                  state <= RUN;
                  busy  <= 1'b1;
               end else if (wrap) begin
                  pre   <= 8'd0;
                  cnt   <= 6'd0;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  busy <= 1'b1;
               end
            end

            default: begin
               pre   <= 8'd0;
               cnt   <= 6'd0;
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_generator.sv
// ----------------------------------------------------------------------------
// tb_pwm_generator
//
// Two DUT instances, PRESCALE=1 and PRESCALE=4, share the same stimulus.
// A period-level model predicts every output on every clock. Directed
// sequences pin pulse widths and period lengths with literal values.
// ----------------------------------------------------------------------------
module tb_pwm_generator;
  localparam int NI = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [5:0] duty = 6'd0;
  bit         cmp_on = 1'b0;

  always #5 clk = ~clk;

  int pre_p [NI] = '{1, 4};

  logic       d_pwm [NI];
  logic       d_ps  [NI];
  logic       d_busy[NI];
  logic [5:0] d_da  [NI];
  logic [1:0] d_st  [NI];

  pwm_generator #(.PRESCALE(1)) u_dut_p1 (
    .clk(clk), .rst(rst), .en(en), .duty(duty),
    .pwm_out(d_pwm[0]), .period_start(d_ps[0]), .busy(d_busy[0]),
    .duty_active(d_da[0]), .dbg_state(d_st[0])
  );

  pwm_generator #(.PRESCALE(4)) u_dut_p4 (
    .clk(clk), .rst(rst), .en(en), .duty(duty),
    .pwm_out(d_pwm[1]), .period_start(d_ps[1]), .busy(d_busy[1]),
    .duty_active(d_da[1]), .dbg_state(d_st[1])
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- period-level model ----------------
  // The model tracks the position in clocks within the period, whether the
  // block is active or draining, and the duty latched for this period.
  bit m_act [NI];
  bit m_drn [NI];
  int m_pos [NI];
  int m_duty[NI];
  bit e_pwm [NI];
  bit e_ps  [NI];
  bit e_busy[NI];
  int e_da  [NI];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        m_act[i] = 0; m_drn[i] = 0; m_pos[i] = 0; m_duty[i] = 0;
        e_pwm[i] = 0; e_ps[i] = 0; e_busy[i] = 0; e_da[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        int  per;
        bit  last;
        per      = 64 * pre_p[i];
        e_pwm[i] = m_act[i] && ((m_pos[i] / pre_p[i]) < m_duty[i]);
        e_ps[i]  = m_act[i] && (m_pos[i] == 0);
        if (!m_act[i]) begin
          if (en) begin
            m_act[i]  = 1;
            m_drn[i]  = 0;
            m_pos[i]  = 0;
            m_duty[i] = int'(duty);
          end
        end else begin
          last = (m_pos[i] == per - 1);
          if (last && (en || !m_drn[i])) m_duty[i] = int'(duty);
          if (last && m_drn[i] && !en) m_act[i] = 0;
          m_pos[i] = (m_pos[i] + 1) % per;
          m_drn[i] = !en;
        end
        e_busy[i] = m_act[i];
        e_da[i]   = m_duty[i];
      end
    end
  end

  // Compare process: every output on every clock, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("pwm_out p%0d", pre_p[i]), int'(d_pwm[i]), int'(e_pwm[i]));
        chk($sformatf("period_start p%0d", pre_p[i]), int'(d_ps[i]), int'(e_ps[i]));
        chk($sformatf("busy p%0d", pre_p[i]), int'(d_busy[i]), int'(e_busy[i]));
        chk($sformatf("duty_active p%0d", pre_p[i]), int'(d_da[i]), e_da[i]);
        chk($sformatf("state_idle p%0d", pre_p[i]), int'(d_st[i] == 2'd0), int'(!e_busy[i]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ps(input int inst);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_ps[inst] && n < 2000);
    chk($sformatf("wait_ps p%0d", pre_p[inst]), int'(d_ps[inst]), 1);
  endtask

  // Starts on a negedge where period_start is high and measures one period.
  // It can change duty at sample index change_at.
  task automatic measure(input int inst, input int change_at, input int new_duty,
                         input int exp_high, input int exp_len);
    int len, high, shape_bad;
    bit done;
    len = 0; high = 0; shape_bad = 0; done = 0;
    while (!done) begin
      if (d_pwm[inst]) high++;
      if ((d_pwm[inst] == 1'b1) != (len < exp_high)) shape_bad++;
      if (len == change_at) duty = 6'(new_duty);
      len++;
      @(negedge clk);
      if (d_ps[inst]) done = 1;
      if (len >= 2000) done = 1;
    end
    chk($sformatf("high clocks p%0d", pre_p[inst]), high, exp_high);
    chk($sformatf("period len p%0d", pre_p[inst]), len, exp_len);
    chk($sformatf("pulse shape p%0d", pre_p[inst]), shape_bad, 0);
  endtask

  // Runs one 64-clock period of the PRESCALE=1 instance. en drops at sample
  // 30 and, if requested, rises again at sample 40.
  task automatic drain_period(input bit reraise, output int high, output int busy_low);
    high = 0; busy_low = 0;
    for (int i = 0; i < 64; i++) begin
      if (d_pwm[0]) high++;
      if (i < 63 && !d_busy[0]) busy_low++;
      if (i == 30) en = 1'b0;
      if (i == 40 && reraise) en = 1'b1;
      if (i < 63) @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int high, busy_low, n, idle_ps, idle_pwm, idle_busy;

    // Reset hold
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset pwm_out", int'(d_pwm[i]), 0);
      chk("reset period_start", int'(d_ps[i]), 0);
      chk("reset busy", int'(d_busy[i]), 0);
      chk("reset duty_active", int'(d_da[i]), 0);
    end
    cmp_on = 1'b1;

    // PRESCALE=1, duty=16
    rst = 1'b1; duty = 6'd16; en = 1'b1;
    @(negedge clk);
    chk("busy after en", int'(d_busy[0]), 1);
    chk("pwm before first period", int'(d_pwm[0]), 0);
    wait_ps(0);
    measure(0, -1, 0, 16, 64);

    // PRESCALE=4, duty=10: 40 clocks high in a 256-clock period
    duty = 6'd10;
    wait_ps(1);
    measure(1, -1, 0, 40, 256);

    // duty 16 -> 40 at cnt=20, takes effect only at the next wrap
    duty = 6'd16;
    wait_ps(0);
    measure(0, 20, 40, 16, 64);
    measure(0, -1, 0, 40, 64);

    // duty=0 then duty=63
    measure(0, 10, 0, 40, 64);
    measure(0, 10, 63, 0, 64);
    measure(0, 10, 50, 63, 64);

    // Drain: en dropped at cnt=30 with duty=50
    drain_period(1'b0, high, busy_low);
    chk("drain high clocks", high, 50);
    chk("drain busy kept", busy_low, 0);
    chk("drain busy end", int'(d_busy[0]), 0);
    idle_ps = 0; idle_pwm = 0; idle_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (d_ps[0]) idle_ps++;
      if (d_pwm[0]) idle_pwm++;
      if (d_busy[0]) idle_busy++;
    end
    chk("idle period_start", idle_ps, 0);
    chk("idle pwm_out", idle_pwm, 0);
    chk("idle busy", idle_busy, 0);

    // en re-raised at cnt=40: continuous, no period restart
    en = 1'b1;
    wait_ps(0);
    drain_period(1'b1, high, busy_low);
    chk("reraise high clocks", high, 50);
    chk("reraise busy kept", busy_low, 0);
    @(negedge clk);
    chk("reraise next period_start", int'(d_ps[0]), 1);
    measure(0, -1, 0, 50, 64);

    // Asynchronous reset in the middle of a high pulse
    repeat (10) @(negedge clk);
    chk("pwm high before reset", int'(d_pwm[0]), 1);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("async pwm_out", int'(d_pwm[i]), 0);
      chk("async period_start", int'(d_ps[i]), 0);
      chk("async busy", int'(d_busy[i]), 0);
      chk("async duty_active", int'(d_da[i]), 0);
    end
    repeat (3) @(negedge clk);
    duty = 6'd20; en = 1'b1; rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_ps[0] && n < 10);
    chk("restart latency", n, 2);
    measure(0, -1, 0, 20, 64);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case a wait is never satisfied
  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
